infix_token_writer: RTL

//  Keypad-side stage upstream of the expression evaluator. Assembles key events into infix tokens.

---
 rtl/infix_token_writer_pkg.sv | 46 ++++
 rtl/infix_token_writer_int24_to_float.sv | 21 ++
 rtl/infix_token_writer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/infix_token_writer_pkg.sv
// rtl/infix_token_writer_pkg.sv - key codes, token codes and FSM states for the infix token writer
package infix_token_writer_pkg;

  localparam int DWIDTH_DEF    = 36;
  localparam int LOG_LEN_DEF   = 9;
  localparam int START_CYC_DEF = 2;

  localparam logic [4:0] KEY_ADD  = 5'd10;
  localparam logic [4:0] KEY_SUB  = 5'd11;
  localparam logic [4:0] KEY_MUL  = 5'd12;
  localparam logic [4:0] KEY_DIV  = 5'd13;
  localparam logic [4:0] KEY_LPAR = 5'd14;
  localparam logic [4:0] KEY_RPAR = 5'd15;
  localparam logic [4:0] KEY_EQ   = 5'd16;
  localparam logic [4:0] KEY_CLR  = 5'd17;

  localparam logic [11:0] OP_LPAR = 12'h150;
  localparam logic [11:0] OP_RPAR = 12'h151;
  localparam logic [11:0] OP_ADD  = 12'h170;
  localparam logic [11:0] OP_SUB  = 12'h171;
  localparam logic [11:0] OP_MUL  = 12'h190;
  localparam logic [11:0] OP_DIV  = 12'h191;

  localparam logic [3:0] TOK_NUM_TAG = 4'h0;
  localparam logic [3:0] TOK_OP_TAG  = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_NUM,
    S_WR_OP,
    S_START,
    S_WAIT
  } state_e;

  function automatic logic [11:0] key_to_op(input logic [4:0] k);
    case (k)
      KEY_ADD:  key_to_op = OP_ADD;
      KEY_SUB:  key_to_op = OP_SUB;
      KEY_MUL:  key_to_op = OP_MUL;
      KEY_DIV:  key_to_op = OP_DIV;
      KEY_LPAR: key_to_op = OP_LPAR;
      default:  key_to_op = OP_RPAR;
    endcase
  endfunction

endpackage

// File: rtl/infix_token_writer_int24_to_float.sv
// rtl/infix_token_writer_int24_to_float.sv - unsigned 24-bit integer to IEEE-754 single conversion
module int24_to_float (
  input  logic [23:0] int_i,
  output logic [31:0] float_o
);

  logic [4:0]  msb;
  logic [23:0] norm;

  // Find the leading one, then left-justify so it drops into the hidden bit.
  always_comb begin
    msb = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (int_i[i]) msb = 5'(i);
    end
    norm = int_i << (5'd23 - msb);
    if (int_i == 24'd0) float_o = 32'h0;
    else                float_o = {1'b0, 8'd127 + {3'b000, msb}, norm[22:0]};
  end

endmodule

// File: rtl/infix_token_writer.sv
// rtl/infix_token_writer.sv - assembles key events into infix tokens and writes them to the infix RAM
module infix_token_writer
  import infix_token_writer_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int LOG_LEN   = LOG_LEN_DEF,
  parameter int START_CYC = START_CYC_DEF
) (
  input  logic               CLK_1MHz,
  input  logic               RST,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  output logic               key_ready,
  input  logic               finish,
  output logic               en_inf,
  output logic               we_inf,
  output logic [LOG_LEN-1:0] addr_inf,
  output logic [DWIDTH-1:0]  dl_inf,
  output logic [LOG_LEN-1:0] top_addr_inf,
  output logic               inf_start,
  output logic               num_ovf,
  output logic               full_err
);

  localparam int CW = $clog2(START_CYC) + 1;

  state_e             state_q, state_d;
  logic [23:0]        acc_q, acc_d;
  logic               pend_q, pend_d;
  logic [LOG_LEN-1:0] wptr_q, wptr_d;
  logic [LOG_LEN-1:0] top_q, top_d;
  logic               full_q, full_d;     // last RAM slot already written
  logic               ovf_q, ovf_d;
  logic               ferr_q, ferr_d;
  logic [11:0]        op_q, op_d;
  logic               then_start_q, then_start_d;  // number flush precedes START, not WR_OP
  logic [CW-1:0]      cnt_q, cnt_d;

  logic        accept, is_digit, is_op, write_tok, en_c;
  logic [27:0] acc_next;
  logic [31:0] acc_float;

  int24_to_float u_conv (
    .int_i  (acc_q),
    .float_o(acc_float)
  );

  assign is_digit  = (key_code <= 5'd9);
  assign is_op     = (key_code >= KEY_ADD) && (key_code <= KEY_RPAR);
  assign key_ready = (state_q == S_IDLE) || ((key_code == KEY_CLR) && (state_q != S_START));
  assign accept    = key_valid && key_ready;
  assign acc_next  = {4'b0000, acc_q} * 28'd10 + 28'(key_code);

  assign en_inf       = en_c;
  assign we_inf       = en_c;
  assign top_addr_inf = top_q;
  assign num_ovf      = ovf_q;
  assign full_err     = ferr_q;

  // State register and datapath registers; async reset abandons any in-flight write.
  always_ff @(posedge CLK_1MHz or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      pend_q       <= 1'b0;
      wptr_q       <= '0;
      top_q        <= '0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ferr_q       <= 1'b0;
      op_q         <= '0;
      then_start_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      wptr_q       <= wptr_d;
      top_q        <= top_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      ferr_q       <= ferr_d;
      op_q         <= op_d;
      then_start_q <= then_start_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic, RAM port drive and start pulse; clear overrides everything last.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    pend_d       = pend_q;
    wptr_d       = wptr_q;
    top_d        = top_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    ferr_d       = ferr_q;
    op_d         = op_q;
    then_start_d = then_start_q;
    cnt_d        = cnt_q;
    write_tok    = 1'b0;
    en_c         = 1'b0;
    addr_inf     = '0;
    dl_inf       = '0;
    inf_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            if (acc_next > 28'hFF_FFFF) begin
              ovf_d = 1'b1;
            end else begin
              acc_d  = acc_next[23:0];
              pend_d = 1'b1;
            end
          end else if (is_op) begin
            op_d         = key_to_op(key_code);
            then_start_d = 1'b0;
            state_d      = pend_q ? S_WR_NUM : S_WR_OP;
          end else if (key_code == KEY_EQ) begin
            if (pend_q) begin
              then_start_d = 1'b1;
              state_d      = S_WR_NUM;
            end else if ((wptr_q != '0) || full_q) begin
              state_d = S_START;
            end
          end
        end
      end
      S_WR_NUM: begin
        write_tok = 1'b1;
        addr_inf  = wptr_q;
        dl_inf    = DWIDTH'({TOK_NUM_TAG, acc_float});
        acc_d     = '0;
        pend_d    = 1'b0;
        state_d   = then_start_q ? S_START : S_WR_OP;
      end
      S_WR_OP: begin
        write_tok = 1'b1;
        addr_inf  = wptr_q;
        dl_inf    = DWIDTH'({TOK_OP_TAG, 20'h0_0000, op_q});
        state_d   = S_IDLE;
      end
      S_START: begin
        inf_start = 1'b1;
        if (cnt_q == CW'(START_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (finish) begin
          state_d = S_IDLE;
          wptr_d  = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (write_tok) begin
      if (full_q) begin
        ferr_d = 1'b1;
      end else begin
        en_c  = 1'b1;
        top_d = wptr_q;
        if (wptr_q == '1) full_d = 1'b1;
        else              wptr_d = wptr_q + 1'b1;
      end
    end

    if (accept && (key_code == KEY_CLR)) begin
      en_c         = 1'b0;
      top_d        = top_q;
      acc_d        = '0;
      pend_d       = 1'b0;
      wptr_d       = '0;
      full_d       = 1'b0;
      ovf_d        = 1'b0;
      ferr_d       = 1'b0;
      cnt_d        = '0;
      then_start_d = 1'b0;
      state_d      = S_IDLE;
    end
  end

endmodule
